rx_operand_loader: RTL and testbench

Upstream stage of the perceptron datapath: consumes bytes from the `uart_rx6` receive FIFO and assembles them into the flattened input vector `x` and weight vector `w` for `weighted_sum_top`. Decodes a simple byte protocol with three headers: load X, load W and Go. Vectors are staged in shadow registers and committed atomically, so the datapath never sees a partially loaded vector. Issues a one-cycle `start` pulse to the weighted-sum stage on command.

---
 rtl/perceptron_pkg.sv | 22 ++
 rtl/operand_byte_assembler.sv | 51 +++++
 rtl/rx_operand_loader.sv | 164 ++++++++++++++++
 tb/tb_rx_operand_loader.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron datapath: protocol header bytes,
// default element width and the loader FSM/target encodings.
package perceptron_pkg;

  localparam logic [7:0] HDR_X  = 8'h58;
  localparam logic [7:0] HDR_W  = 8'h57;
  localparam logic [7:0] HDR_GO = 8'h47;

  localparam int ELEM_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT
  } state_e;

  typedef enum logic {
    TGT_X,
    TGT_W
  } target_e;

endpackage

// File: rtl/operand_byte_assembler.sv
// Collects three big-endian bytes into one W-bit element; elem is valid
// combinationally in the cycle the third byte is consumed (elem_done).
module operand_byte_assembler
  import perceptron_pkg::*;
#(
  parameter int W = ELEM_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic [7:0]   byte_in,
  output logic [W-1:0] elem,
  output logic         elem_done
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] sh_q, sh_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    sh_d       = sh_q;
    elem_done  = 1'b0;
    if (clear) begin
      byte_idx_d = 2'd0;
      sh_d       = 16'd0;
    end else if (en) begin
      sh_d = {sh_q[7:0], byte_in};
      if (byte_idx_q == 2'd2) begin
        byte_idx_d = 2'd0;
        elem_done  = 1'b1;
      end else begin
        byte_idx_d = byte_idx_q + 2'd1;
      end
    end
  end

  // Truncation drops the unused high bits of the first byte.
  assign elem = W'({sh_q, byte_in});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q <= 2'd0;
      sh_q       <= 16'd0;
    end else begin
      byte_idx_q <= byte_idx_d;
      sh_q       <= sh_d;
    end
  end

endmodule

// File: rtl/rx_operand_loader.sv
// Byte-protocol loader feeding weighted_sum_top: shadows x/w packets and
// commits them atomically. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
module rx_operand_loader
  import perceptron_pkg::*;
#(
  parameter int          N              = 8,
  parameter int          W              = ELEM_W,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     rx_data,
  input  logic           rx_data_present,
  output logic           rx_read,
  output logic [W*N-1:0] x,
  output logic [W*N-1:0] w,
  output logic           start,
  output logic           busy,
  output logic [7:0]     err_count
);

  localparam int            IW        = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_ELEM = IW'(N - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e         state_q, state_d;
  target_e        tgt_q, tgt_d;
  logic [IW-1:0]  elem_idx_q, elem_idx_d;
  logic [W*N-1:0] shadow_q, shadow_d;
  logic [W*N-1:0] x_q, x_d;
  logic [W*N-1:0] w_q, w_d;
  logic           x_ok_q, x_ok_d;
  logic           w_ok_q, w_ok_d;
  logic           start_q, start_d;
  logic [7:0]     err_count_q, err_count_d;

  logic           consume;
  logic           is_load_hdr;
  logic           asm_clear;
  logic           asm_en;
  logic [W-1:0]   elem;
  logic           elem_done;
  logic           timeout;

  assign rx_read     = rx_data_present && rst_n;
  assign consume     = rx_read;
  assign is_load_hdr = (rx_data == HDR_X) || (rx_data == HDR_W);
  assign asm_en      = consume && (state_q == ST_LOAD);
  assign asm_clear   = consume && (state_q != ST_LOAD) && is_load_hdr;

`ifdef LOADER_TIMEOUT_EN
  logic [15:0] gap_q, gap_d;
  assign timeout = (state_q == ST_LOAD) && !consume && (gap_q == TIMEOUT_CYCLES - 16'd1);
`else
  assign timeout = 1'b0;
`endif

  operand_byte_assembler #(.W(W)) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (asm_clear),
    .en        (asm_en),
    .byte_in   (rx_data),
    .elem      (elem),
    .elem_done (elem_done)
  );

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    elem_idx_d  = elem_idx_q;
    shadow_d    = shadow_q;
    x_d         = x_q;
    w_d         = w_q;
    x_ok_d      = x_ok_q;
    w_ok_d      = w_ok_q;
    start_d     = 1'b0;
    err_count_d = err_count_q;
`ifdef LOADER_TIMEOUT_EN
    gap_d = (consume || state_q != ST_LOAD) ? 16'd0 : gap_q + 16'd1;
`endif

    case (state_q)
      ST_LOAD: begin
        if (elem_done) begin
          shadow_d[elem_idx_q*W +: W] = elem;
          if (elem_idx_q == LAST_ELEM) state_d = ST_COMMIT;
          else                         elem_idx_d = elem_idx_q + 1'b1;
        end else if (timeout) begin
          state_d     = ST_IDLE;
          shadow_d    = '0;
          err_count_d = sat_inc(err_count_q);
        end
      end
      ST_COMMIT: begin
        if (tgt_q == TGT_X) begin
          x_d    = shadow_q;
          x_ok_d = 1'b1;
        end else begin
          w_d    = shadow_q;
          w_ok_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: ;
    endcase

    // Header decode runs in IDLE and COMMIT; in COMMIT it sees the flag just set.
    if (consume && state_q != ST_LOAD) begin
      if (is_load_hdr) begin
        tgt_d      = (rx_data == HDR_X) ? TGT_X : TGT_W;
        elem_idx_d = '0;
        state_d    = ST_LOAD;
      end else if (rx_data == HDR_GO && x_ok_d && w_ok_d) begin
        start_d = 1'b1;
      end else begin
        err_count_d = sat_inc(err_count_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tgt_q       <= TGT_X;
      elem_idx_q  <= '0;
      shadow_q    <= '0;
      x_q         <= '0;
      w_q         <= '0;
      x_ok_q      <= 1'b0;
      w_ok_q      <= 1'b0;
      start_q     <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      elem_idx_q  <= elem_idx_d;
      shadow_q    <= shadow_d;
      x_q         <= x_d;
      w_q         <= w_d;
      x_ok_q      <= x_ok_d;
      w_ok_q      <= w_ok_d;
      start_q     <= start_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_q <= 16'd0;
    else        gap_q <= gap_d;
  end
`endif

  assign x         = x_q;
  assign w         = w_q;
  assign start     = start_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_count = err_count_q;

endmodule

// File: tb/tb_rx_operand_loader.sv
// Self-checking bench for rx_operand_loader (N=2, W=18) against a
// packet-level reference model; timeout scenario runs with LOADER_TIMEOUT_EN.
module tb_rx_operand_loader;

  localparam int N = 2;
  localparam int W = 18;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     rx_data = 8'h00;
  logic           rx_data_present = 1'b0;
  logic           rx_read;
  logic [W*N-1:0] x;
  logic [W*N-1:0] w;
  logic           start;
  logic           busy;
  logic [7:0]     err_count;

  int checks = 0;
  int passes = 0;
  int start_cnt = 0;

  logic [17:0] mx [2];
  logic [17:0] mw [2];
  bit          mxok, mwok;
  int          merr;

  rx_operand_loader #(.N(N), .W(W), .TIMEOUT_CYCLES(16'd100)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_data         (rx_data),
    .rx_data_present (rx_data_present),
    .rx_read         (rx_read),
    .x               (x),
    .w               (w),
    .start           (start),
    .busy            (busy),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (start === 1'b1) start_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [17:0] elem_of(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2);
    int v;
    v = (int'(b0) % 4) * 65536 + int'(b1) * 256 + int'(b2);
    return 18'(v);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = '0;
      mw[i] = '0;
    end
    mxok = 0;
    mwok = 0;
    merr = 0;
  endfunction

  function automatic void m_bad();
    merr = (merr < 255) ? merr + 1 : 255;
  endfunction

  function automatic void m_load(input bit is_w, input logic [7:0] p [6]);
    for (int i = 0; i < 2; i++) begin
      if (is_w) mw[i] = elem_of(p[3*i], p[3*i+1], p[3*i+2]);
      else      mx[i] = elem_of(p[3*i], p[3*i+1], p[3*i+2]);
    end
    if (is_w) mwok = 1;
    else      mxok = 1;
  endfunction

  function automatic logic [35:0] m_vec(input bit is_w);
    return is_w ? {mw[1], mw[0]} : {mx[1], mx[0]};
  endfunction

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data_present = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    rx_data_present = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] hdr, input logic [7:0] p [6], input int maxgap);
    send_byte(hdr);
    for (int i = 0; i < 6; i++) begin
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(posedge clk);
      send_byte(p[i]);
    end
  endtask

  task automatic rand_payload(output logic [7:0] p [6]);
    for (int i = 0; i < 6; i++) p[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx_data_present = 1'b1;
    m_reset();
    #1;
    checks++; if (rx_read !== 1'b0) $display("FAIL reset_rx_read got %b want 0", rx_read); else passes++;
    checks++; if (x !== 36'd0) $display("FAIL reset_x got %h want 0", x); else passes++;
    checks++; if (w !== 36'd0) $display("FAIL reset_w got %h want 0", w); else passes++;
    checks++; if ({start, busy} !== 2'b00) $display("FAIL reset_start_busy got %b want 00", {start, busy}); else passes++;
    checks++; if (err_count !== 8'd0) $display("FAIL reset_err got %0d want 0", err_count); else passes++;
    repeat (2) @(negedge clk);
    rx_data_present = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_go_early();
    int c0;
    c0 = start_cnt;
    send_byte(8'h47);
    m_bad();
    checks++; if (start !== 1'b0) $display("FAIL go_early_start got %b want 0", start); else passes++;
    checks++; if (err_count !== 8'(merr)) $display("FAIL go_early_err got %0d want %0d", err_count, merr); else passes++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (start_cnt !== c0) $display("FAIL go_early_pulses got %0d want %0d", start_cnt - c0, 0); else passes++;
  endtask

  task automatic test_load_xw();
    logic [7:0] px [6];
    logic [7:0] pw [6];
    int c0;
    px = '{8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h0B};
    pw = '{8'h00, 8'h00, 8'h02, 8'h03, 8'hFF, 8'hFF};
    c0 = start_cnt;
    send_packet(8'h58, px, 0);
    checks++; if (x !== 36'd0) $display("FAIL load_x_early got %h want 0", x); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL load_x_busy got %b want 1", busy); else passes++;
    m_load(0, px);
    @(posedge clk);
    #1;
    checks++; if (x !== {18'h0000B, 18'h0000A}) $display("FAIL load_x got %h want %h", x, {18'h0000B, 18'h0000A}); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL load_x_idle got %b want 0", busy); else passes++;
    send_packet(8'h57, pw, 0);
    checks++; if (w !== 36'd0) $display("FAIL load_w_early got %h want 0", w); else passes++;
    m_load(1, pw);
    @(posedge clk);
    #1;
    checks++; if (w !== {18'h3FFFF, 18'h00002}) $display("FAIL load_w got %h want %h", w, {18'h3FFFF, 18'h00002}); else passes++;
    checks++; if (start_cnt !== c0) $display("FAIL load_no_start got %0d pulses want 0", start_cnt - c0); else passes++;
    checks++; if (err_count !== 8'(merr)) $display("FAIL load_err got %0d want %0d", err_count, merr); else passes++;
  endtask

  task automatic test_go();
    int c0;
    c0 = start_cnt;
    send_byte(8'h47);
    checks++; if (start !== 1'b1) $display("FAIL go_start got %b want 1", start); else passes++;
    @(posedge clk);
    #1;
    checks++; if (start !== 1'b0) $display("FAIL go_pulse_width got %b want 0", start); else passes++;
    checks++; if (start_cnt - c0 !== 1) $display("FAIL go_pulses got %0d want 1", start_cnt - c0); else passes++;
    checks++; if (err_count !== 8'(merr)) $display("FAIL go_err got %0d want %0d", err_count, merr); else passes++;
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = start_cnt;
    send_byte(8'h47);
    checks++; if (start !== 1'b1) $display("FAIL b2b_first got %b want 1", start); else passes++;
    send_byte(8'h47);
    checks++; if (start !== 1'b1) $display("FAIL b2b_second got %b want 1", start); else passes++;
    @(posedge clk);
    #1;
    checks++; if (start !== 1'b0) $display("FAIL b2b_end got %b want 0", start); else passes++;
    checks++; if (start_cnt - c0 !== 2) $display("FAIL b2b_pulses got %0d want 2", start_cnt - c0); else passes++;
  endtask

  task automatic test_byte0_mask();
    logic [7:0] p [6];
    rand_payload(p);
    p[0] = 8'hFF; p[1] = 8'h12; p[2] = 8'h34;
    send_packet(8'h58, p, 1);
    m_load(0, p);
    @(posedge clk);
    #1;
    checks++; if (x[17:0] !== 18'h31234) $display("FAIL byte0_mask got %h want %h", x[17:0], 18'h31234); else passes++;
    checks++; if (x !== m_vec(0)) $display("FAIL byte0_vec got %h want %h", x, m_vec(0)); else passes++;
  endtask

  task automatic test_overwrite();
    logic [7:0] p [6];
    logic [35:0] old;
    old = m_vec(0);
    rand_payload(p);
    send_byte(8'h58);
    for (int i = 0; i < 3; i++) send_byte(p[i]);
    checks++; if (x !== old) $display("FAIL overwrite_hold got %h want %h", x, old); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL overwrite_busy got %b want 1", busy); else passes++;
    for (int i = 3; i < 6; i++) send_byte(p[i]);
    m_load(0, p);
    @(posedge clk);
    #1;
    checks++; if (x !== m_vec(0)) $display("FAIL overwrite_new got %h want %h", x, m_vec(0)); else passes++;
  endtask

  task automatic test_commit_go();
    logic [7:0] p [6];
    int c0;
    do_reset();
    rand_payload(p);
    send_packet(8'h58, p, 0);
    m_load(0, p);
    rand_payload(p);
    send_packet(8'h57, p, 0);
    checks++; if (w !== 36'd0) $display("FAIL commit_go_w_early got %h want 0", w); else passes++;
    c0 = start_cnt;
    send_byte(8'h47);
    m_load(1, p);
    checks++; if (start !== 1'b1) $display("FAIL commit_go_start got %b want 1", start); else passes++;
    checks++; if (w !== m_vec(1)) $display("FAIL commit_go_w got %h want %h", w, m_vec(1)); else passes++;
    checks++; if (err_count !== 8'(merr)) $display("FAIL commit_go_err got %0d want %0d", err_count, merr); else passes++;
    @(posedge clk);
    #1;
    checks++; if (start_cnt - c0 !== 1) $display("FAIL commit_go_pulses got %0d want 1", start_cnt - c0); else passes++;
  endtask

  task automatic test_random();
    logic [7:0] p [6];
    logic [7:0] b;
    bit exp_start;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          bit is_w;
          is_w = ($urandom_range(0, 1) == 1);
          rand_payload(p);
          send_packet(is_w ? 8'h57 : 8'h58, p, 2);
          m_load(is_w, p);
          @(posedge clk);
          #1;
          checks++; if (x !== m_vec(0)) $display("FAIL rand_x it%0d got %h want %h", it, x, m_vec(0)); else passes++;
          checks++; if (w !== m_vec(1)) $display("FAIL rand_w it%0d got %h want %h", it, w, m_vec(1)); else passes++;
        end
        2: begin
          exp_start = mxok && mwok;
          send_byte(8'h47);
          if (!exp_start) m_bad();
          checks++; if (start !== exp_start) $display("FAIL rand_go it%0d got %b want %b", it, start, exp_start); else passes++;
          checks++; if (err_count !== 8'(merr)) $display("FAIL rand_go_err it%0d got %0d want %0d", it, err_count, merr); else passes++;
        end
        default: begin
          do b = 8'($urandom_range(0, 255));
          while (b == 8'h58 || b == 8'h57 || b == 8'h47);
          send_byte(b);
          m_bad();
          checks++; if (err_count !== 8'(merr)) $display("FAIL rand_bad it%0d got %0d want %0d", it, err_count, merr); else passes++;
        end
      endcase
    end
  endtask

  task automatic test_err_sat();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send_byte(8'h41);
      m_bad();
      if (i == 0 || i == 254 || i == 255) begin
        checks++; if (err_count !== 8'(merr)) $display("FAIL err_sat_%0d got %0d want %0d", i, err_count, merr); else passes++;
      end
    end
    checks++; if (err_count !== 8'd255) $display("FAIL err_sat_final got %0d want 255", err_count); else passes++;
  endtask

  task automatic test_async_reset();
    logic [7:0] p [6];
    rand_payload(p); p[0] = 8'h03;
    send_packet(8'h58, p, 0);
    rand_payload(p); p[3] = 8'h02;
    send_packet(8'h57, p, 0);
    @(posedge clk);
    rand_payload(p);
    send_byte(8'h58);
    for (int i = 0; i < 3; i++) send_byte(p[i]);
    #2;
    rst_n = 1'b0;
    rx_data_present = 1'b1;
    m_reset();
    #1;
    checks++; if ({x, w} !== 72'd0) $display("FAIL async_xw got %h want 0", {x, w}); else passes++;
    checks++; if ({start, busy, rx_read} !== 3'b000) $display("FAIL async_ctl got %b want 000", {start, busy, rx_read}); else passes++;
    checks++; if (err_count !== 8'd0) $display("FAIL async_err got %0d want 0", err_count); else passes++;
    @(negedge clk);
    rx_data_present = 1'b0;
    rst_n = 1'b1;
    rand_payload(p);
    send_packet(8'h58, p, 1);
    m_load(0, p);
    @(posedge clk);
    #1;
    checks++; if (x !== m_vec(0)) $display("FAIL async_reload got %h want %h", x, m_vec(0)); else passes++;
    send_byte(8'h47);
    m_bad();
    checks++; if ({start, err_count} !== {1'b0, 8'(merr)}) $display("FAIL async_go got %b/%0d want 0/%0d", start, err_count, merr); else passes++;
  endtask

`ifdef LOADER_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] p [6];
    logic [35:0] old;
    old = m_vec(0);
    send_byte(8'h58);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (99) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) $display("FAIL timeout_early got %b want 1", busy); else passes++;
    @(posedge clk);
    #1;
    m_bad();
    checks++; if (busy !== 1'b0) $display("FAIL timeout_busy got %b want 0", busy); else passes++;
    checks++; if (err_count !== 8'(merr)) $display("FAIL timeout_err got %0d want %0d", err_count, merr); else passes++;
    checks++; if (x !== old) $display("FAIL timeout_x got %h want %h", x, old); else passes++;
    rand_payload(p);
    send_packet(8'h58, p, 0);
    m_load(0, p);
    @(posedge clk);
    #1;
    checks++; if (x !== m_vec(0)) $display("FAIL timeout_reload got %h want %h", x, m_vec(0)); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_go_early();
    test_load_xw();
    test_go();
    test_back_to_back();
    test_byte0_mask();
    test_overwrite();
    test_commit_go();
    test_random();
`ifdef LOADER_TIMEOUT_EN
    test_timeout();
`endif
    test_err_sat();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
